// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: records retired register writebacks with a cycle stamp
// into a first-word-fall-through FIFO, counting entries lost while full.
module commit_trace_buffer #(
  parameter int DATA_W       = 32,
  parameter int REG_AW       = 5,
  parameter int DEPTH        = 16,
  parameter int CYC_W        = 16,
  parameter int FILTER_ZERO  = 1,
  parameter int HALT_ON_FULL = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     trace_en,
  input  logic [DATA_W-1:0]        pc,
  input  logic                     wb_en,
  input  logic [REG_AW-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CYC_W-1:0]         out_cycle,
  output logic [DATA_W-1:0]        out_pc,
  output logic [REG_AW-1:0]        out_addr,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              drop_cnt,
  output logic                     overflow,
  output logic                     halted
);

  localparam int AW    = $clog2(DEPTH);
  localparam int ENT_W = CYC_W + DATA_W + REG_AW + DATA_W;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [CYC_W-1:0] cycle_cnt;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [ENT_W-1:0] mem [DEPTH];
  logic [ENT_W-1:0] ent_p0;
  logic             vld_p0;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  // Capture stage: qualify the commit and assemble the entry.
  always_comb begin
    vld_p0 = trace_en && wb_en && !halted &&
             !((FILTER_ZERO != 0) && (wb_addr == '0));
    ent_p0 = {cycle_cnt, pc, wb_addr, wb_data};
    full   = (level == FULL_LVL);
    pop    = out_valid && out_ready;
    push   = vld_p0 && (!full || pop);
    drop   = vld_p0 && full && !pop;
  end

  // Storage stage: control state is reset, entry storage is not.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_cnt <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
      halted    <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (drop) begin
        drop_cnt <= sat_inc16(drop_cnt);
        overflow <= 1'b1;
        if (HALT_ON_FULL != 0) halted <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= ent_p0;
  end

  // Output stage: head entry falls through combinationally.
  always_comb begin
    out_valid = (level != '0);
    {out_cycle, out_pc, out_addr, out_data} = mem[rd_ptr];
  end

endmodule
